// File: rtl/trc_pkg.sv
// Shared types and constants for the end-of-test result checker.
package trc_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SIG_REQ  = 2'd1,
    ST_SIG_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } trc_state_e;

  localparam int TRC_MODE_X3  = 0;
  localparam int TRC_MODE_SIG = 1;

endpackage

// File: rtl/trc_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module trc_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance only when enabled and not yet saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/test_result_checker.sv
// End-of-test monitor: counts cycles/instructions, detects the tohost loop,
// then decides pass/fail from x3 or from a word-by-word signature walk.
module test_result_checker
  import trc_pkg::*;
#(
  parameter logic [31:0] TOHOST_PC   = 32'h8000_0086,
  parameter int          TOHOST_HITS = 8,
  parameter int          MODE        = TRC_MODE_X3,
  parameter logic [31:0] SIG_BASE    = 32'h8000_2000,
  parameter int          SIG_WORDS   = 256,
  parameter int          RD_LAT      = 1,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic [31:0] de_pc,
  input  logic        de_valid,
  input  logic        de_stall,
  input  logic [31:0] x3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [11:0] exp_idx,
  input  logic [31:0] exp_rdata,
  input  logic        exp_valid,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt,
  output logic [12:0] mismatch_cnt,
  output logic [11:0] first_bad_idx
);

  trc_state_e  state_q, state_d;
  logic [12:0] idx_q, idx_d;
  logic [2:0]  wait_q, wait_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [11:0] exp_idx_q, exp_idx_d;
  logic [11:0] first_bad_q, first_bad_d;
  logic [7:0]  hit_cnt;

  logic in_run, hit_now, hit_end, timeout_end, sample, word_bad;

  // The hit criterion deliberately ignores de_stall so results line up with
  // the historical regression numbers.
  assign in_run      = (state_q == ST_RUN);
  assign hit_now     = de_valid && (de_pc == TOHOST_PC);
  assign hit_end     = in_run && hit_now && (hit_cnt == 8'(TOHOST_HITS - 1));
  assign timeout_end = in_run && (cycle_cnt == 32'(TIMEOUT_CYC - 1));
  assign sample      = (state_q == ST_SIG_WAIT) && (wait_q == 3'd0);
  assign word_bad    = sample && exp_valid && (exp_rdata != mem_rdata);

  trc_sat_counter #(.W(32)) u_cycle_cnt (
    .clk(clk), .rst(cpurst), .en(in_run), .cnt(cycle_cnt)
  );

  trc_sat_counter #(.W(32)) u_inst_cnt (
    .clk(clk), .rst(cpurst), .en(in_run && de_valid && !de_stall), .cnt(inst_cnt)
  );

  trc_sat_counter #(.W(8)) u_hit_cnt (
    .clk(clk), .rst(cpurst), .en(in_run && hit_now), .cnt(hit_cnt)
  );

  trc_sat_counter #(.W(13)) u_mismatch_cnt (
    .clk(clk), .rst(cpurst), .en(word_bad), .cnt(mismatch_cnt)
  );

  // State, walk index and read-latency down-counter registers
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: hit beats timeout; one signature read outstanding at a time
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (hit_end) begin
          if (MODE == TRC_MODE_SIG) begin
            state_d = ST_SIG_REQ;
            idx_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timeout_end) begin
          state_d = ST_DONE;
        end
      end
      ST_SIG_REQ: begin
        state_d = ST_SIG_WAIT;
        wait_d  = 3'(RD_LAT - 1);
      end
      ST_SIG_WAIT: begin
        if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else if (!exp_valid) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 13'd1;
          if (idx_d == 13'(SIG_WORDS)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SIG_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Registered outputs, computed from the transition about to happen
  always_comb begin
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    exp_idx_d   = exp_idx_q;
    first_bad_d = first_bad_q;
    if (state_d == ST_SIG_REQ) begin
      mem_req_d  = 1'b1;
      mem_addr_d = SIG_BASE + {17'd0, idx_d, 2'b00};
      exp_idx_d  = idx_d[11:0];
    end
    if (word_bad && (first_bad_q == 12'hFFF)) begin
      first_bad_d = idx_q[11:0];
    end
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      done_d = 1'b1;
      if (state_q == ST_RUN) begin
        pass_d    = hit_end && (x3 == 32'd1);
        timeout_d = !hit_end;
      end else begin
        // Include the word being judged this cycle, not yet in the counter
        pass_d = (mismatch_cnt == 13'd0) && !word_bad;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (cpurst) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= SIG_BASE;
      exp_idx_q   <= '0;
      first_bad_q <= 12'hFFF;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      exp_idx_q   <= exp_idx_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign exp_idx       = exp_idx_q;
  assign first_bad_idx = first_bad_q;

endmodule

// File: tb/tb_test_result_checker.sv
// Bench for test_result_checker: x3 mode, timeout and signature mode instances.
module tb_test_result_checker;

  localparam logic [31:0] TOHOST = 32'h8000_0086;
  localparam logic [31:0] SBASE  = 32'h8000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // x3-mode instance (also used for timeout)
  logic        rst0, de_valid0, de_stall0, mem_req0, done0, pass0, timeout0, exp_valid0;
  logic [31:0] de_pc0, x3_0, mem_addr0, mem_rdata0, exp_rdata0, cyc0, inst0;
  logic [11:0] exp_idx0, fb0;
  logic [12:0] mm0;

  // signature-mode instance
  logic        rst1, de_valid1, de_stall1, mem_req1, done1, pass1, timeout1, exp_valid1;
  logic [31:0] de_pc1, x3_1, mem_addr1, mem_rdata1, exp_rdata1, cyc1, inst1;
  logic [11:0] exp_idx1, fb1;
  logic [12:0] mm1;

  test_result_checker #(
    .TOHOST_HITS(8), .MODE(0), .TIMEOUT_CYC(100)
  ) dut0 (
    .clk(clk), .cpurst(rst0), .de_pc(de_pc0), .de_valid(de_valid0), .de_stall(de_stall0),
    .x3(x3_0), .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
    .exp_idx(exp_idx0), .exp_rdata(exp_rdata0), .exp_valid(exp_valid0), .done(done0),
    .pass(pass0), .timeout(timeout0), .cycle_cnt(cyc0), .inst_cnt(inst0),
    .mismatch_cnt(mm0), .first_bad_idx(fb0)
  );

  test_result_checker #(
    .TOHOST_HITS(2), .MODE(1), .RD_LAT(2), .SIG_WORDS(6)
  ) dut1 (
    .clk(clk), .cpurst(rst1), .de_pc(de_pc1), .de_valid(de_valid1), .de_stall(de_stall1),
    .x3(x3_1), .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
    .exp_idx(exp_idx1), .exp_rdata(exp_rdata1), .exp_valid(exp_valid1), .done(done1),
    .pass(pass1), .timeout(timeout1), .cycle_cnt(cyc1), .inst_cnt(inst1),
    .mismatch_cnt(mm1), .first_bad_idx(fb1)
  );

  // Memory model for dut1: two-cycle read pipeline keyed by address / index
  logic [31:0] mem_img [8];
  logic [31:0] exp_img [8];
  int          n_valid = 0;
  logic        p_req  [2];
  logic [31:0] p_addr [2];
  logic [11:0] p_idx  [2];

  always @(posedge clk) begin
    p_req[0]  <= mem_req1;
    p_addr[0] <= mem_addr1;
    p_idx[0]  <= exp_idx1;
    p_req[1]  <= p_req[0];
    p_addr[1] <= p_addr[0];
    p_idx[1]  <= p_idx[0];
  end

  always_comb begin
    mem_rdata1 = mem_img[p_addr[1][4:2]];
    exp_rdata1 = exp_img[p_idx[1][2:0]];
    exp_valid1 = (int'(p_idx[1]) < n_valid);
  end

  task automatic hold_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    de_valid0 = 1'b0; de_stall0 = 1'b0; de_pc0 = '0; x3_0 = '0;
    de_valid1 = 1'b0; de_stall1 = 1'b0; de_pc1 = '0; x3_1 = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    n_tests++;
    if ({done0, pass0, timeout0, mem_req0} !== 4'b0000 || cyc0 !== 32'd0 || inst0 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 flags=%b cyc=%0d inst=%0d required flags=0000 cyc=0 inst=0",
               {done0, pass0, timeout0, mem_req0}, cyc0, inst0);
    end
    n_tests++;
    if ({done1, pass1, timeout1, mem_req1} !== 4'b0000 || mem_addr1 !== SBASE ||
        exp_idx1 !== 12'd0 || mm1 !== 13'd0 || fb1 !== 12'hFFF) begin
      n_fail++;
      $display("FAIL reset_dut1 flags=%b addr=%h idx=%0d mm=%0d fb=%h required 0000 %h 0 0 fff",
               {done1, pass1, timeout1, mem_req1}, mem_addr1, exp_idx1, mm1, fb1, SBASE);
    end
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  // 8 hits on odd cycles 1..15, some stalled; x3 holds x3v only on the final hit
  task automatic test_x3(input logic [31:0] x3v, input logic exp_pass);
    int exp_inst = 0;
    hold_reset();
    rst0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      de_valid0 = 1'b1;
      de_stall0 = (i % 3 == 2);
      de_pc0    = (i % 2 == 1 && i < 16) ? TOHOST : 32'h8000_0000 + 32'(i * 4);
      x3_0      = (i == 15) ? x3v : 32'd7;
      if (i < 16 && !de_stall0) exp_inst++;
      @(negedge clk);
      if (i == 14) begin
        n_tests++;
        if (done0 !== 1'b0) begin
          n_fail++; $display("FAIL x3_done_early done=%b required 0", done0);
        end
      end
      if (i == 15) begin
        n_tests++;
        if (done0 !== 1'b1 || pass0 !== exp_pass || timeout0 !== 1'b0) begin
          n_fail++;
          $display("FAIL x3_verdict done=%b pass=%b timeout=%b required 1 %b 0",
                   done0, pass0, timeout0, exp_pass);
        end
      end
    end
    de_valid0 = 1'b0;
    n_tests++;
    if (inst0 !== 32'(exp_inst) || cyc0 !== 32'd16 || done0 !== 1'b1 || pass0 !== exp_pass) begin
      n_fail++;
      $display("FAIL x3_counters inst=%0d cyc=%0d done=%b pass=%b required %0d 16 1 %b",
               inst0, cyc0, done0, pass0, exp_inst, exp_pass);
    end
  endtask

  task automatic test_timeout();
    hold_reset();
    rst0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      de_valid0 = 1'b0;
      @(negedge clk);
      if (i == 98) begin
        n_tests++;
        if (done0 !== 1'b0) begin
          n_fail++; $display("FAIL timeout_early done=%b required 0", done0);
        end
      end
    end
    n_tests++;
    if (done0 !== 1'b1 || timeout0 !== 1'b1 || pass0 !== 1'b0 || cyc0 !== 32'd100) begin
      n_fail++;
      $display("FAIL timeout_verdict done=%b timeout=%b pass=%b cyc=%0d required 1 1 0 100",
               done0, timeout0, pass0, cyc0);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (cyc0 !== 32'd100 || done0 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_freeze cyc=%0d done=%b required 100 1", cyc0, done0);
    end
  endtask

  // 8th hit lands on the 100th cycle: the hit path must win
  task automatic test_hit_and_timeout();
    hold_reset();
    rst0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      de_valid0 = (i >= 92);
      de_pc0    = TOHOST;
      x3_0      = 32'd1;
      @(negedge clk);
    end
    de_valid0 = 1'b0;
    n_tests++;
    if (done0 !== 1'b1 || timeout0 !== 1'b0 || pass0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_vs_timeout done=%b timeout=%b pass=%b required 1 0 1",
               done0, timeout0, pass0);
    end
  endtask

  // Two hits on cycles 0,1 then scoreboard every signature read
  task automatic run_sig(input int n_reads, output int done_at);
    int exp_q[$];
    int k;
    hold_reset();
    rst1 = 1'b0;
    for (int j = 0; j < n_reads; j++) exp_q.push_back(j);
    done_at = -1;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      de_valid1 = (i < 2);
      de_pc1    = TOHOST;
      @(negedge clk);
      if (mem_req1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sig_extra_read addr=%h required no request", mem_addr1);
        end else begin
          k = exp_q.pop_front();
          if (mem_addr1 !== SBASE + 32'(k * 4) || exp_idx1 !== 12'(k)) begin
            n_fail++;
            $display("FAIL sig_read addr=%h idx=%0d required %h %0d",
                     mem_addr1, exp_idx1, SBASE + 32'(k * 4), k);
          end
        end
      end
      if (done1) done_at = i;
    end
    de_valid1 = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || done_at < 0) begin
      n_fail++;
      $display("FAIL sig_completion reads_left=%0d done_at=%0d required 0 and done", exp_q.size(), done_at);
    end
  endtask

  task automatic test_sig_match();
    int done_at;
    for (int j = 0; j < 8; j++) begin
      mem_img[j] = 32'h1000 + 32'(j * 32'h111);
      exp_img[j] = 32'h1000 + 32'(j * 32'h111);
    end
    n_valid = 4;
    run_sig(5, done_at);
    n_tests++;
    if (done_at != 16) begin
      n_fail++; $display("FAIL sig_latency done_at=%0d required 16", done_at);
    end
    n_tests++;
    if (pass1 !== 1'b1 || mm1 !== 13'd0 || fb1 !== 12'hFFF || timeout1 !== 1'b0 ||
        cyc1 !== 32'd2 || inst1 !== 32'd2) begin
      n_fail++;
      $display("FAIL sig_match pass=%b mm=%0d fb=%h to=%b cyc=%0d inst=%0d required 1 0 fff 0 2 2",
               pass1, mm1, fb1, timeout1, cyc1, inst1);
    end
  endtask

  task automatic test_sig_bad();
    int done_at;
    for (int j = 0; j < 8; j++) begin
      mem_img[j] = 32'hA000 + 32'(j);
      exp_img[j] = 32'hA000 + 32'(j);
    end
    exp_img[2] = 32'hDEADBEEF;
    mem_img[2] = 32'h0000_0000;
    n_valid = 8;
    run_sig(6, done_at);
    n_tests++;
    if (done_at != 19) begin
      n_fail++; $display("FAIL sig_limit_latency done_at=%0d required 19", done_at);
    end
    n_tests++;
    if (pass1 !== 1'b0 || mm1 !== 13'd1 || fb1 !== 12'd2) begin
      n_fail++;
      $display("FAIL sig_bad pass=%b mm=%0d fb=%0d required 0 1 2", pass1, mm1, fb1);
    end
  endtask

  task automatic test_reset_mid_walk();
    int seen = 0;
    int extra = 0;
    n_valid = 8;
    hold_reset();
    rst1 = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      de_valid1 = (i < 2);
      de_pc1    = TOHOST;
      @(negedge clk);
      if (mem_req1) seen = 1;
    end
    de_valid1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (seen == 0 || {done1, pass1, timeout1, mem_req1} !== 4'b0000 || mem_addr1 !== SBASE ||
        exp_idx1 !== 12'd0 || cyc1 !== 32'd0 || mm1 !== 13'd0 || fb1 !== 12'hFFF) begin
      n_fail++;
      $display("FAIL reset_mid_walk seen=%0d flags=%b addr=%h idx=%0d cyc=%0d required 1 0000 %h 0 0",
               seen, {done1, pass1, timeout1, mem_req1}, mem_addr1, exp_idx1, cyc1, SBASE);
    end
    rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req1) extra++;
    end
    n_tests++;
    if (extra != 0 || cyc1 !== 32'd10 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart extra_reqs=%0d cyc=%0d done=%b required 0 10 0", extra, cyc1, done1);
    end
  endtask

  initial begin
    mem_rdata0 = '0; exp_rdata0 = '0; exp_valid0 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      mem_img[j] = '0;
      exp_img[j] = '0;
    end
    test_reset();
    test_x3(32'd1, 1'b1);
    test_x3(32'd5, 1'b0);
    test_timeout();
    test_hit_and_timeout();
    test_sig_match();
    test_sig_bad();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_result_checker.md
# test_result_checker

Synthesizable end-of-test monitor for core regression runs, on FPGA or in simulation. It counts cycles and retired instructions, and detects test completion by counting issues of a configurable tohost PC. It then decides pass/fail in one of two modes: checking x3 == 1, or walking a signature region through a memory read port and comparing it word-by-word against an expected-signature source. It sits beside `top`, observes the decode→execute boundary of the core, and borrows a read port of the data-side memory once the test has ended.

## Interface
- `TOHOST_PC`, 32'h8000_0086: PC whose valid issue marks the write-to-host loop.
- `TOHOST_HITS`, 8: number of qualifying issues of `TOHOST_PC` that ends the test; range 1..255.
- `MODE`, 0: 0 = x3 check; 1 = signature compare.
- `SIG_BASE`, 32'h8000_2000: byte address of signature word 0; must be 4-byte aligned.
- `SIG_WORDS`, 256: maximum signature words compared; range 1..4096.
- `RD_LAT`, 1: cycles from `mem_req` to valid `mem_rdata`/`exp_rdata`; range 1..4.
- `TIMEOUT_CYC`, 50000: cycles in RUN before timeout is declared.
- `clk` in 1: single clock.
- `cpurst` in 1: reset, synchronous, active-high.
- `de_pc` in 32: PC of the instruction at the decode→execute register.
- `de_valid` in 1: `de_pc` holds a valid instruction.
- `de_stall` in 1: decode stage stalled.
- `x3` in 32: architectural register x3.
- `mem_req` out 1: single-cycle signature read strobe.
- `mem_addr` out 32: signature read byte address.
- `mem_rdata` in 32: read data, valid `RD_LAT` cycles after `mem_req`.
- `exp_idx` out 12: index into the expected-signature store; presented with `mem_req`.
- `exp_rdata` in 32: expected word, same latency as `mem_rdata`.
- `exp_valid` in 1: expected word exists. 0 terminates the compare. Sampled with `exp_rdata`.
- `done` out 1: verdict reached; sticky.
- `pass` out 1: test passed; meaningful only when `done`=1.
- `timeout` out 1: ended by timeout.
- `cycle_cnt` out 32: cycles spent in RUN.
- `inst_cnt` out 32: instructions retired in RUN.
- `mismatch_cnt` out 13: number of mismatching signature words.
- `first_bad_idx` out 12: index of the first mismatching word; all-ones if there was none.

## Operation
- FSM states: RUN, SIG_REQ, SIG_WAIT, DONE. Reset enters RUN.
- RUN:
  - `cycle_cnt` increments every cycle.
  - `inst_cnt` increments when `de_valid & !de_stall`.
  - Hit counter increments when `de_valid & (de_pc == TOHOST_PC)`. Stall is deliberately ignored, matching the established regression criterion.
  - All counters saturate at all-ones.
- RUN exit, priority order:
  1. Hit counter reaches `TOHOST_HITS`. If `MODE`=0, go to DONE with `pass = (x3 == 32'd1)` sampled that cycle. If `MODE`=1, go to SIG_REQ with idx=0.
  2. Otherwise, `cycle_cnt` reaches `TIMEOUT_CYC`. Go to DONE with `timeout`=1 and `pass`=0.
  - If both conditions occur in the same cycle, the hit wins.
- SIG_REQ: drive `mem_req`=1, `mem_addr = SIG_BASE + {idx,2'b00}`, `exp_idx`=idx for one cycle, then go to SIG_WAIT.
- SIG_WAIT: wait `RD_LAT` cycles using a down-counter, then sample the read data:
  - If `exp_valid`=0, go to DONE.
  - Otherwise, if `exp_rdata != mem_rdata`, increment `mismatch_cnt` and set `first_bad_idx` if it is still all-ones.
  - Then increment idx. If idx reaches `SIG_WORDS`, go to DONE; otherwise go to SIG_REQ.
- One read is outstanding at a time; there is no pipelining.
- DONE: absorbing until reset.
  - `done`=1.
  - In `MODE`=1 without timeout, `pass = (mismatch_cnt == 0)`.
  - `cycle_cnt` and `inst_cnt` freeze on leaving RUN.
- The x3 comparison is exact over all 32 bits. The address add is 32-bit, modulo 2^32.

## Timing
- Reset values: `done`/`pass`/`timeout`/`mem_req`=0; `mem_addr`=`SIG_BASE`; `exp_idx`=0; `cycle_cnt`/`inst_cnt`/`mismatch_cnt`=0; `first_bad_idx`=all-ones.
- Reset asserted mid-compare aborts the walk, with no further `mem_req`. Counters restart from 0 on the first non-reset edge.
- `done` rises one cycle after the terminating hit (`MODE`=0) or after the timeout cycle.
- `MODE`=1 latency from the terminating hit to `done`: N·(`RD_LAT`+1)+1 cycles for N words compared.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `trc_pkg`: FSM state enum and mode constants `TRC_MODE_X3`/`TRC_MODE_SIG`.
- One sub-module, `trc_sat_counter`: parametrised-width saturating counter with enable. Used for cycle, instruction, hit and mismatch counts.

## Test plan
- `MODE`=0: issue `TOHOST_PC` 8 times with x3=1 → `done`=1 and `pass`=1 one cycle after the 8th hit; `inst_cnt` equals the number of non-stalled valid cycles.
- `MODE`=0: 8 hits with x3=5 → `pass`=0, `timeout`=0.
- `MODE`=1, `RD_LAT`=2, 4 words with matching memory, 5th `exp_valid`=0 → 5 reads at 0x80002000..0x80002010, `pass`=1, `mismatch_cnt`=0.
- `MODE`=1: word 2 differs (0xDEADBEEF vs 0x00000000) → `mismatch_cnt`=1, `first_bad_idx`=2, `pass`=0.
- No hits, `TIMEOUT_CYC`=100 → `done`=1 and `timeout`=1 one cycle after the 100th cycle; `cycle_cnt`=100.
- Hit and timeout in the same cycle → hit path taken. Reset asserted during SIG_WAIT → all outputs return to reset values next cycle.
